key_press_queue: RTL and testbench



---
 rtl/pianotiles_pkg.sv | 28 ++
 rtl/key_debounce.sv | 64 ++++++
 rtl/key_press_queue.sv | 171 +++++++++++++++++
 tb/tb_key_press_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pianotiles_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pianotiles_pkg
// Purpose  : Shared types, constants and the key-to-column mapping used by
//            the piano-tiles input stage, game FSM and vga_player.
// Revision : 1.0 - initial release
// ============================================================================
package pianotiles_pkg;

  localparam int NUM_COLS               = 4;
  localparam int DEBOUNCE_TICKS_DEFAULT = 3;

  // Column index on the playfield, 0 = leftmost.
  typedef logic [1:0] col_t;

  // Press-acceptance FSM: LOCK holds off all presses until every key is up.
  typedef enum logic [0:0] {
    ACC_IDLE = 1'b0,
    ACC_LOCK = 1'b1
  } accept_state_e;

  // Buttons are wired right-to-left: key_n[3] is column 0, key_n[0] is column 3.
  function automatic col_t key_to_col(input logic [1:0] key_idx);
    return ~key_idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Two-flop synchroniser plus counter debouncer for one active-low
//            button. Exposes the debounced level, its next value and a
//            combinational press edge aligned with the edge where it flips.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic rate_clock,
  input  logic reset,
  input  logic key_n_raw,
  output logic stable,
  output logic stable_next,
  output logic press_edge
);

  localparam logic [3:0] TICKS_C = 4'(DEBOUNCE_TICKS);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       stable_q, stable_d;
  logic [3:0] cnt_q, cnt_d;

  // Next-state: shift the synchroniser and count ticks of disagreement.
  always_comb begin
    sync1_d  = key_n_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = 4'd0;
    if (sync2_q != stable_q) begin
      if (cnt_q + 4'd1 == TICKS_C) begin
        stable_d = ~stable_q;
        cnt_d    = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // State registers; released (1) is the idle level for every stage.
  always_ff @(posedge rate_clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= 4'd0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable      = stable_q;
  assign stable_next = stable_d;
  // High during the tick whose closing edge flips the level released->pressed.
  assign press_edge  = stable_q & ~stable_d;

endmodule
`default_nettype wire

// File: rtl/key_press_queue.sv
`default_nettype none
// ============================================================================
// Module   : key_press_queue
// Purpose  : Debounces four active-low buttons, accepts single-key presses as
//            column events (chords rejected and flagged) and queues them in a
//            small FIFO drained with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module key_press_queue
  import pianotiles_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       rate_clock,
  input  logic       reset,
  input  logic [3:0] key_n,
  input  logic       flush,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [1:0] ev_col,
  output logic       chord_err,
  output logic       overflow,
  output logic [3:0] occupancy
);

  localparam int         PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

  logic [NUM_COLS-1:0] stable_vec;
  logic [NUM_COLS-1:0] stable_next_vec;
  logic [NUM_COLS-1:0] press_edge_vec;

  // One debouncer per button.
  for (genvar i = 0; i < NUM_COLS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_debounce (
      .rate_clock (rate_clock),
      .reset      (reset),
      .key_n_raw  (key_n[i]),
      .stable     (stable_vec[i]),
      .stable_next(stable_next_vec[i]),
      .press_edge (press_edge_vec[i])
    );
  end

  // --------------------------------------------------------------------------
  // Accept FSM
  // --------------------------------------------------------------------------
  accept_state_e state_q, state_d;
  logic          chord_err_q, chord_err_d;
  logic          push;
  col_t          push_col;
  logic [2:0]    num_press;
  logic          others_pressed;

  // Classify this tick's press edges: lone press -> push, anything else -> chord.
  always_comb begin
    state_d        = state_q;
    chord_err_d    = 1'b0;
    push           = 1'b0;
    push_col       = '0;
    num_press      = 3'd0;
    for (int i = 0; i < NUM_COLS; i++) begin
      num_press = num_press + {2'b0, press_edge_vec[i]};
      if (press_edge_vec[i]) begin
        push_col = key_to_col(2'(i));
      end
    end
    // A key releasing on this same edge already counts as released.
    others_pressed = |(~stable_next_vec & ~press_edge_vec);
    case (state_q)
      ACC_IDLE: begin
        if ((num_press >= 3'd2) || ((num_press == 3'd1) && others_pressed)) begin
          chord_err_d = 1'b1;
          state_d     = ACC_LOCK;
        end else if (num_press == 3'd1) begin
          push = 1'b1;
        end
      end
      ACC_LOCK: begin
        if (&stable_vec) begin
          state_d = ACC_IDLE;
        end
      end
      default: state_d = ACC_IDLE;
    endcase
  end

  // FSM state and the one-tick chord flag.
  always_ff @(posedge rate_clock or posedge reset) begin
    if (reset) begin
      state_q     <= ACC_IDLE;
      chord_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chord_err_q <= chord_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Event FIFO
  // --------------------------------------------------------------------------
  col_t             mem_q [FIFO_DEPTH];
  col_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_pop;
  logic             do_push;
  logic             full;

  // Queue bookkeeping; a pop frees the slot a same-edge push needs when full.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    full       = (count_q == DEPTH_C);
    do_pop     = (count_q != 4'd0) && ev_ready;
    do_push    = push && (!full || do_pop);
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = 4'd0;
      overflow_d = 1'b0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_col;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + {3'b0, do_push} - {3'b0, do_pop};
      if (push && full && !do_pop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge rate_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign ev_valid  = (count_q != 4'd0);
  assign ev_col    = mem_q[rd_ptr_q];
  assign chord_err = chord_err_q;
  assign overflow  = overflow_q;
  assign occupancy = count_q;

endmodule
`default_nettype wire

// File: tb/tb_key_press_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_press_queue
// Purpose  : Self-checking bench for key_press_queue with an expected-column
//            scoreboard popped whenever the consumer takes an event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_press_queue;

  logic       rate_clock = 1'b0;
  logic       reset;
  logic [3:0] key_n;
  logic       flush;
  logic       ev_ready;
  logic       ev_valid;
  logic [1:0] ev_col;
  logic       chord_err;
  logic       overflow;
  logic [3:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];
  int mon_exp;
  int pulses;

  key_press_queue #(
    .DEBOUNCE_TICKS(3),
    .FIFO_DEPTH    (4)
  ) u_dut (
    .rate_clock(rate_clock),
    .reset     (reset),
    .key_n     (key_n),
    .flush     (flush),
    .ev_ready  (ev_ready),
    .ev_valid  (ev_valid),
    .ev_col    (ev_col),
    .chord_err (chord_err),
    .overflow  (overflow),
    .occupancy (occupancy)
  );

  always #5 rate_clock = ~rate_clock;

  task automatic check_eq(input string tag, input logic [31:0] observed,
                          input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then settle 2 time units past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge rate_clock);
    #2;
  endtask

  // Press key k for hold ticks, release for gap ticks; record expected column.
  task automatic press_key(input int k, input int hold, input int gap,
                           input int col, input bit accepted);
    if (accepted) sb.push_back(col);
    key_n[k] = 1'b0;
    tick(hold);
    key_n[k] = 1'b1;
    tick(gap);
  endtask

  task automatic drain(input int budget);
    ev_ready = 1'b1;
    for (int i = 0; i < budget && ev_valid; i++) tick(1);
    check_eq("drain_done", ev_valid, 0);
    check_eq("sb_empty", sb.size(), 0);
    ev_ready = 1'b0;
  endtask

  // Consumer side: every handshake must match the oldest expected column.
  always @(negedge rate_clock) begin
    if (!reset && ev_valid && ev_ready) begin
      check_eq("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        check_eq("ev_col_pop", ev_col, mon_exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    key_n    = 4'hF;
    flush    = 1'b0;
    ev_ready = 1'b0;
    tick(2);
    check_eq("rst_ev_valid", ev_valid, 0);
    check_eq("rst_ev_col", ev_col, 0);
    check_eq("rst_chord", chord_err, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_occ", occupancy, 0);
    reset = 1'b0;
    tick(2);

    // Single press latency on key_n[2] -> column 1.
    sb.push_back(1);
    key_n[2] = 1'b0;
    tick(4);
    check_eq("lat_early_valid", ev_valid, 0);
    tick(1);
    check_eq("lat_valid", ev_valid, 1);
    check_eq("lat_col", ev_col, 1);
    check_eq("lat_occ", occupancy, 1);
    tick(5);
    key_n[2] = 1'b1;
    tick(10);
    check_eq("single_occ", occupancy, 1);
    drain(10);

    // Glitches shorter than the debounce window on key_n[0].
    key_n[0] = 1'b0; tick(2);
    key_n[0] = 1'b1; tick(1);
    key_n[0] = 1'b0; tick(2);
    key_n[0] = 1'b1; tick(8);
    check_eq("glitch_occ", occupancy, 0);
    press_key(0, 8, 8, 3, 1'b1);
    check_eq("glitch_then_hold_occ", occupancy, 1);
    drain(10);

    // Chord: key_n[3] held, then key_n[1] added.
    sb.push_back(0);
    key_n[3] = 1'b0;
    tick(8);
    check_eq("chord_first_occ", occupancy, 1);
    key_n[1] = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      pulses += int'(chord_err);
    end
    check_eq("chord_pulses", pulses, 1);
    check_eq("chord_no_push", occupancy, 1);
    key_n[3] = 1'b1;
    key_n[1] = 1'b1;
    tick(8);
    press_key(1, 7, 7, 2, 1'b1);
    check_eq("after_chord_occ", occupancy, 2);
    drain(10);

    // Overflow: five presses into a 4-deep queue.
    press_key(3, 7, 7, 0, 1'b1);
    press_key(2, 7, 7, 1, 1'b1);
    press_key(1, 7, 7, 2, 1'b1);
    press_key(0, 7, 7, 3, 1'b1);
    press_key(3, 7, 7, 0, 1'b0);
    check_eq("ovf_occ", occupancy, 4);
    check_eq("ovf_flag", overflow, 1);
    ev_ready = 1'b1;
    tick(4);
    check_eq("ovf_drain_valid", ev_valid, 0);
    check_eq("ovf_drain_sb", sb.size(), 0);
    ev_ready = 1'b0;
    check_eq("ovf_sticky", overflow, 1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check_eq("flush_ovf", overflow, 0);
    check_eq("flush_occ", occupancy, 0);

    // Full queue with simultaneous push and pop.
    press_key(3, 7, 7, 0, 1'b1);
    press_key(2, 7, 7, 1, 1'b1);
    press_key(1, 7, 7, 2, 1'b1);
    press_key(0, 7, 7, 3, 1'b1);
    sb.push_back(0);
    key_n[3] = 1'b0;
    tick(4);
    check_eq("pp_pre_occ", occupancy, 4);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    check_eq("pp_occ", occupancy, 4);
    check_eq("pp_ovf", overflow, 0);
    tick(4);
    key_n[3] = 1'b1;
    tick(7);
    drain(10);

    // Reset mid-operation with two queued events and a key held.
    press_key(2, 7, 7, 1, 1'b1);
    press_key(1, 7, 7, 2, 1'b1);
    check_eq("pre_rst_occ", occupancy, 2);
    key_n[0] = 1'b0;
    tick(2);
    #3;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", ev_valid, 0);
    check_eq("mid_rst_col", ev_col, 0);
    check_eq("mid_rst_chord", chord_err, 0);
    check_eq("mid_rst_ovf", overflow, 0);
    check_eq("mid_rst_occ", occupancy, 0);
    sb.delete();
    tick(2);
    reset = 1'b0;
    sb.push_back(3);
    tick(10);
    check_eq("post_rst_occ", occupancy, 1);
    check_eq("post_rst_col", ev_col, 3);
    key_n[0] = 1'b1;
    tick(10);
    check_eq("post_rst_single", occupancy, 1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    sb.delete();
    check_eq("flush2_occ", occupancy, 0);
    check_eq("flush2_ovf", overflow, 0);
    check_eq("flush2_valid", ev_valid, 0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
